// File: rtl/victim_way_sel_if.sv
// Lookup/refill/response bundle for the victim way selector.
// The cache pipeline drives through the master side; victim_way_sel takes the slave side.
interface victim_way_sel_if #(
  parameter int WAY_BITS = 3,
  parameter int IDX_BITS = 6
);
  localparam int WAY_NUM = 1 << WAY_BITS;

  logic                req_valid;
  logic [IDX_BITS-1:0] req_index;
  logic [WAY_NUM-1:0]  req_way_valid;
  logic                fill_valid;
  logic [IDX_BITS-1:0] fill_index;
  logic [WAY_BITS-1:0] fill_way_id;
  logic                resp_valid;
  logic [WAY_BITS-1:0] resp_way_id;
  logic [WAY_NUM-1:0]  resp_way_oh;

  modport master (
    output req_valid, req_index, req_way_valid, fill_valid, fill_index, fill_way_id,
    input  resp_valid, resp_way_id, resp_way_oh
  );

  modport slave (
    input  req_valid, req_index, req_way_valid, fill_valid, fill_index, fill_way_id,
    output resp_valid, resp_way_id, resp_way_oh
  );
endinterface

// File: rtl/victim_way_sel.sv
// Victim way selection: lowest invalid way first, otherwise the per-set round-robin
// pointer. The result is registered, so the response arrives one cycle after the request.
module victim_way_sel #(
  parameter int WAY_BITS = 3,
  parameter int IDX_BITS = 6
) (
  input logic             clk,
  input logic             rst,
  victim_way_sel_if.slave bus
);
  localparam int WAY_NUM = 1 << WAY_BITS;
  localparam int SET_NUM = 1 << IDX_BITS;

  logic [SET_NUM-1:0][WAY_BITS-1:0] ptr_q, ptr_d;
  logic                             resp_vld_q, resp_vld_d;
  logic [WAY_BITS-1:0]              resp_id_q, resp_id_d;
  logic [WAY_NUM-1:0]               resp_oh_q, resp_oh_d;

  logic [WAY_BITS-1:0] fill_cur, fill_nxt, eff_ptr, inv_id, victim;
  logic                fill_adv, any_inv;

  // The pointer advances only when the refill lands on the way it points at;
  // a refill into an invalid way leaves the pointer where it is.
  always_comb begin
    fill_cur = ptr_q[bus.fill_index];
    fill_adv = bus.fill_valid && (bus.fill_way_id == fill_cur);
    fill_nxt = fill_adv ? fill_cur + 1'b1 : fill_cur;
    ptr_d    = ptr_q;
    if (fill_adv) ptr_d[bus.fill_index] = fill_nxt;
  end

  // A refill to the queried set in the same cycle is forwarded to the query.
  always_comb begin
    if (bus.fill_valid && (bus.fill_index == bus.req_index)) eff_ptr = fill_nxt;
    else                                                     eff_ptr = ptr_q[bus.req_index];
  end

  always_comb begin
    any_inv = ~&bus.req_way_valid;
    inv_id  = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (!bus.req_way_valid[i]) inv_id = WAY_BITS'(i);
    end
    victim = any_inv ? inv_id : eff_ptr;
  end

  always_comb begin
    resp_vld_d = bus.req_valid;
    resp_id_d  = resp_id_q;
    resp_oh_d  = resp_oh_q;
    if (bus.req_valid) begin
      resp_id_d = victim;
      resp_oh_d = WAY_NUM'(1) << victim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_id_q  <= '0;
      resp_oh_q  <= WAY_NUM'(1);
    end else begin
      ptr_q      <= ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_id_q  <= resp_id_d;
      resp_oh_q  <= resp_oh_d;
    end
  end

  assign bus.resp_valid  = resp_vld_q;
  assign bus.resp_way_id = resp_id_q;
  assign bus.resp_way_oh = resp_oh_q;
endmodule

// File: tb/tb_victim_way_sel.sv
// Directed checks of victim_way_sel: an 8-way/64-set instance driven from a vector
// table plus corner sequences, and a 4-way/4-set instance for the narrow configuration.
module tb_victim_way_sel;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  victim_way_sel_if #(.WAY_BITS(3), .IDX_BITS(6)) b8 ();
  victim_way_sel_if #(.WAY_BITS(2), .IDX_BITS(2)) b2 ();

  victim_way_sel #(.WAY_BITS(3), .IDX_BITS(6)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  victim_way_sel #(.WAY_BITS(2), .IDX_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic rv, input logic [5:0] ridx, input logic [7:0] rvv,
                      input logic fv, input logic [5:0] fidx, input logic [2:0] fway);
    b8.req_valid = rv; b8.req_index = ridx; b8.req_way_valid = rvv;
    b8.fill_valid = fv; b8.fill_index = fidx; b8.fill_way_id = fway;
  endtask

  task automatic drv2(input logic rv, input logic [1:0] ridx, input logic [3:0] rvv,
                      input logic fv, input logic [1:0] fidx, input logic [1:0] fway);
    b2.req_valid = rv; b2.req_index = ridx; b2.req_way_valid = rvv;
    b2.fill_valid = fv; b2.fill_index = fidx; b2.fill_way_id = fway;
  endtask

  task automatic exp8(input string n, input logic v, input logic [2:0] id, input logic [7:0] oh);
    chk({n, "_valid"}, 32'(b8.resp_valid), 32'(v));
    chk({n, "_id"}, 32'(b8.resp_way_id), 32'(id));
    chk({n, "_oh"}, 32'(b8.resp_way_oh), 32'(oh));
  endtask

  // One-hot output must always be the decode of the binary id.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv8_oh", 32'(b8.resp_way_oh), 32'(8'(1) << b8.resp_way_id));
      chk("inv2_oh", 32'(b2.resp_way_oh), 32'(4'(1) << b2.resp_way_id));
    end
  end

  typedef struct {
    logic       rv;
    logic [5:0] ridx;
    logic [7:0] rvv;
    logic       fv;
    logic [5:0] fidx;
    logic [2:0] fway;
    logic       ev;
    logic [2:0] eid;
    logic [7:0] eoh;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Pointer state evolves through the table; expected values assume all pointers start at 0.
    tbl[0]  = '{1'b1, 6'd5, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b1, 3'd0, 8'h01};
    tbl[1]  = '{1'b0, 6'd0, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b0, 3'd0, 8'h01};
    tbl[2]  = '{1'b1, 6'd5, 8'b1110_1011, 1'b0, 6'd0, 3'd0, 1'b1, 3'd2, 8'h04};
    tbl[3]  = '{1'b0, 6'd0, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b0, 3'd2, 8'h04};
    tbl[4]  = '{1'b1, 6'd0, 8'b0111_1111, 1'b0, 6'd0, 3'd0, 1'b1, 3'd7, 8'h80};
    tbl[5]  = '{1'b1, 6'd0, 8'b1111_1110, 1'b0, 6'd0, 3'd0, 1'b1, 3'd0, 8'h01};
    tbl[6]  = '{1'b1, 6'd0, 8'b1011_1111, 1'b0, 6'd0, 3'd0, 1'b1, 3'd6, 8'h40};
    tbl[7]  = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd9, 3'd0, 1'b0, 3'd6, 8'h40};
    tbl[8]  = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd9, 3'd1, 1'b0, 3'd6, 8'h40};
    tbl[9]  = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd9, 3'd6, 1'b0, 3'd6, 8'h40};
    tbl[10] = '{1'b1, 6'd9, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b1, 3'd2, 8'h04};
    tbl[11] = '{1'b1, 6'd9, 8'hFF,        1'b1, 6'd9, 3'd5, 1'b1, 3'd2, 8'h04};
    tbl[12] = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd7, 3'd0, 1'b0, 3'd2, 8'h04};
    tbl[13] = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd7, 3'd1, 1'b0, 3'd2, 8'h04};
    tbl[14] = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd7, 3'd2, 1'b0, 3'd2, 8'h04};
    tbl[15] = '{1'b0, 6'd0, 8'hFF,        1'b1, 6'd7, 3'd3, 1'b0, 3'd2, 8'h04};
    tbl[16] = '{1'b1, 6'd7, 8'hFF,        1'b1, 6'd7, 3'd4, 1'b1, 3'd5, 8'h20};
    tbl[17] = '{1'b1, 6'd7, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b1, 3'd5, 8'h20};
    tbl[18] = '{1'b1, 6'd4, 8'hFF,        1'b1, 6'd7, 3'd5, 1'b1, 3'd0, 8'h01};
    tbl[19] = '{1'b1, 6'd7, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b1, 3'd6, 8'h40};
    tbl[20] = '{1'b1, 6'd7, 8'b1111_1011, 1'b1, 6'd7, 3'd6, 1'b1, 3'd2, 8'h04};
    tbl[21] = '{1'b1, 6'd7, 8'hFF,        1'b0, 6'd0, 3'd0, 1'b1, 3'd7, 8'h80};
    tbl[22] = '{1'b1, 6'd7, 8'hFF,        1'b1, 6'd7, 3'd7, 1'b1, 3'd0, 8'h01};

    rst = 1'b1;
    drv8(1'b1, 6'd5, 8'hFF, 1'b1, 6'd5, 3'd0);
    drv2(1'b1, 2'd1, 4'hF, 1'b1, 2'd1, 2'd0);
    tick();
    tick();
    drv8(1'b0, 6'd0, 8'hFF, 1'b0, 6'd0, 3'd0);
    drv2(1'b0, 2'd0, 4'hF, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    exp8("reset", 1'b0, 3'd0, 8'h01);
    chk("reset2_valid", 32'(b2.resp_valid), 32'd0);
    chk("reset2_oh", 32'(b2.resp_way_oh), 32'h1);
    inv_en = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drv8(tbl[i].rv, tbl[i].ridx, tbl[i].rvv, tbl[i].fv, tbl[i].fidx, tbl[i].fway);
      tick();
      exp8($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eid, tbl[i].eoh);
    end

    // Round-robin walk of set 3; set 4 stays at 0 throughout.
    for (int k = 0; k < 8; k++) begin
      drv8(1'b0, 6'd0, 8'hFF, 1'b1, 6'd3, 3'(k));
      tick();
      chk($sformatf("rr%0d_idle", k), 32'(b8.resp_valid), 32'd0);
      drv8(1'b1, 6'd3, 8'hFF, 1'b0, 6'd0, 3'd0);
      tick();
      exp8($sformatf("rr%0d_set3", k), 1'b1, 3'((k + 1) % 8), 8'(1) << ((k + 1) % 8));
      drv8(1'b1, 6'd4, 8'hFF, 1'b0, 6'd0, 3'd0);
      tick();
      exp8($sformatf("rr%0d_set4", k), 1'b1, 3'd0, 8'h01);
    end

    // Reset arriving in the response cycle drops it, along with the req seen during reset.
    drv8(1'b1, 6'd5, 8'b1110_1011, 1'b0, 6'd0, 3'd0);
    tick();
    exp8("prerst", 1'b1, 3'd2, 8'h04);
    drv8(1'b1, 6'd9, 8'hFF, 1'b1, 6'd9, 3'd2);
    rst = 1'b1;
    tick();
    exp8("midrst", 1'b0, 3'd0, 8'h01);
    rst = 1'b0;
    drv8(1'b0, 6'd0, 8'hFF, 1'b0, 6'd0, 3'd0);
    tick();
    exp8("postrst", 1'b0, 3'd0, 8'h01);
    drv8(1'b1, 6'd9, 8'hFF, 1'b0, 6'd0, 3'd0);
    tick();
    exp8("ptrclr", 1'b1, 3'd0, 8'h01);
    drv8(1'b0, 6'd0, 8'hFF, 1'b0, 6'd0, 3'd0);

    // Narrow configuration: four advancing fills wrap set 1 back to 0.
    for (int k = 0; k < 4; k++) begin
      drv2(1'b0, 2'd0, 4'hF, 1'b1, 2'd1, 2'(k));
      tick();
      if (k == 1) begin
        drv2(1'b1, 2'd1, 4'hF, 1'b0, 2'd0, 2'd0);
        tick();
        chk("n2_mid_id", 32'(b2.resp_way_id), 32'd2);
        chk("n2_mid_oh", 32'(b2.resp_way_oh), 32'h4);
      end
    end
    drv2(1'b1, 2'd1, 4'hF, 1'b0, 2'd0, 2'd0);
    tick();
    chk("n2_wrap_valid", 32'(b2.resp_valid), 32'd1);
    chk("n2_wrap_id", 32'(b2.resp_way_id), 32'd0);
    chk("n2_wrap_oh", 32'(b2.resp_way_oh), 32'h1);
    drv2(1'b1, 2'd2, 4'b1011, 1'b0, 2'd0, 2'd0);
    tick();
    chk("n2_inv_id", 32'(b2.resp_way_id), 32'd2);
    chk("n2_inv_oh", 32'(b2.resp_way_oh), 32'h4);
    drv2(1'b0, 2'd0, 4'hF, 1'b0, 2'd0, 2'd0);
    tick();
    chk("n2_hold_valid", 32'(b2.resp_valid), 32'd0);
    chk("n2_hold_id", 32'(b2.resp_way_id), 32'd2);

    tick();
    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
